// File: rtl/mult_wb_buffer.sv
// mult_wb_buffer: non-stallable result FIFO between the mult/div unit and writeback.
// Optional zero-latency bypass when the buffer is empty: define MULT_WB_BYPASS_EN.
module mult_wb_buffer #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned SKID          = 2,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned XLEN          = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  input  logic [XLEN-1:0]          result_i,
  output logic                     ready_o,
  output logic                     wb_valid_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]          wb_result_o,
  input  logic                     wb_ready_i,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] SKID_C  = CNT_W'(SKID);

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          result;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  logic   empty;
  logic   full;
  logic   in_ok;
  logic   fifo_pop;
  logic   push;
  entry_t head;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign in_ok    = valid_i && !flush_i;
  assign fifo_pop = !empty && wb_ready_i;
  assign head     = mem_q[rd_ptr_q];

`ifdef MULT_WB_BYPASS_EN
  logic bypass;
  assign bypass = empty && in_ok;
  // A bypassed result taken by writeback in the same cycle never occupies a slot.
  assign push   = in_ok && !(bypass && wb_ready_i) && (!full || fifo_pop);

  always_comb begin
    wb_valid_o    = !empty;
    wb_trans_id_o = head.trans_id;
    wb_result_o   = head.result;
    if (bypass) begin
      wb_valid_o    = 1'b1;
      wb_trans_id_o = trans_id_i;
      wb_result_o   = result_i;
    end
  end
`else
  assign push          = in_ok && (!full || fifo_pop);
  assign wb_valid_o    = !empty;
  assign wb_trans_id_o = head.trans_id;
  assign wb_result_o   = head.result;
`endif

  // Credit to issue: keep SKID slots free for ops already inside the multiplier.
  assign ready_o    = (DEPTH_C - count_q) > SKID_C;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (in_ok && full && !fifo_pop) overflow_q <= 1'b1;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push)     wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (fifo_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(push) - CNT_W'(fifo_pop);
      end
    end
  end

  // NOTE: entry storage is deliberately not reset; outputs are qualified by wb_valid_o.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{trans_id: trans_id_i, result: result_i};
  end

endmodule
